// File: rtl/mem_sa_pkg.sv
// Shared types for the MKIO subaddress message buffer.
//   wr_state_t : receive-side message assembly states
//   rd_state_t : host-side readout states
package mem_sa_pkg;

  typedef enum logic [0:0] {
    WIdle,
    WFill
  } wr_state_t;

  typedef enum logic [1:0] {
    RIdle,
    RFetch,
    RStream
  } rd_state_t;

endpackage

// File: rtl/mem_sdp.sv
// Single-clock simple dual-port RAM with registered read.
//   clk_i   : clock
//   we_i    : write enable; waddr_i / wdata_i write address and data
//   re_i    : read enable; rdata_o updates one cycle after re_i with mem[raddr_i]
//   rdata_o : registered read data, holds its value while re_i is low
module mem_sdp #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 7
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_sa_buf.sv
// Multi-slot message buffer between the 1553 word decoder and the host bus.
// One RAM is split into CH_NUM slots of 2**ADDR_WIDTH words; address = {slot, word_idx}.
//   clock, reset                : single clock, synchronous active-high reset
//   wr_start/wr_ch              : open a message on a slot (drops the slot's old message)
//   wr_en/data                  : append a word to the open message
//   wr_commit/wr_abort          : close (mark valid) or discard the open message
//   wr_err                      : pulse, wr_start refused because the slot is being read
//   rd_req/rd_ch                : start readout of a committed slot
//   q/rd_valid/rd_ready/rd_last : readout stream with valid/ready handshake
//   rd_empty                    : pulse, rd_req to a slot without a committed message
//   ch_valid/ch_ovf             : per-slot committed and overflow flags
//   rd_cnt                      : word count of slot rd_ch
module mem_sa_buf
  import mem_sa_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned CH_NUM     = 4,
  localparam int unsigned CH_WIDTH  = $clog2(CH_NUM)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_start,
  input  logic [CH_WIDTH-1:0]   wr_ch,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wr_commit,
  input  logic                  wr_abort,
  output logic                  wr_err,
  input  logic                  rd_req,
  input  logic [CH_WIDTH-1:0]   rd_ch,
  output logic [DATA_WIDTH-1:0] q,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic                  rd_last,
  output logic                  rd_empty,
  output logic [CH_NUM-1:0]     ch_valid,
  output logic [CH_NUM-1:0]     ch_ovf,
  output logic [ADDR_WIDTH:0]   rd_cnt
);

  localparam int unsigned PtrW    = ADDR_WIDTH + 1;
  localparam int unsigned RamAddrW = ADDR_WIDTH + CH_WIDTH;
  localparam logic [PtrW-1:0] SlotWords = PtrW'(2 ** ADDR_WIDTH);

  wr_state_t              wr_state_q, wr_state_d;
  logic [CH_WIDTH-1:0]    wslot_q, wslot_d;
  logic [PtrW-1:0]        wptr_q, wptr_d;
  logic                   wovf_q, wovf_d;
  logic                   wr_err_q, wr_err_d;

  rd_state_t              rd_state_q, rd_state_d;
  logic [CH_WIDTH-1:0]    rslot_q, rslot_d;
  logic [PtrW-1:0]        rptr_q, rptr_d;
  logic                   rd_valid_q, rd_valid_d;
  logic                   rd_empty_q, rd_empty_d;

  logic [CH_NUM-1:0]      ch_valid_q, ch_valid_d;
  logic [CH_NUM-1:0]      ch_ovf_q, ch_ovf_d;
  logic [PtrW-1:0]        cnt_q [CH_NUM];
  logic [PtrW-1:0]        cnt_d [CH_NUM];

  logic                   rd_accept, rd_fire, rd_is_last, rd_done;
  logic                   start_refused, wr_open, wr_close;

  logic                   ram_we, ram_re;
  logic [RamAddrW-1:0]    ram_waddr, ram_raddr;
  logic [DATA_WIDTH-1:0]  ram_rdata;

  mem_sdp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (RamAddrW)
  ) u_ram (
    .clk_i   (clock),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (data),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign rd_accept  = (rd_state_q == RIdle) && rd_req && ch_valid_q[rd_ch];
  assign rd_fire    = rd_valid_q && rd_ready;
  // rptr runs one ahead of the displayed word, so the last word shows when rptr == count.
  assign rd_is_last = rd_valid_q && (rptr_q == cnt_q[rslot_q]);
  // A slot under readout (or being claimed by a read this cycle) cannot be reopened.
  assign start_refused = ((rd_state_q != RIdle) && (rslot_q == wr_ch)) ||
                         (rd_accept && (rd_ch == wr_ch));

  // ---------------------------------------------------------------- state registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_state_q <= WIdle;
      wslot_q    <= '0;
      wptr_q     <= '0;
      wovf_q     <= 1'b0;
      wr_err_q   <= 1'b0;
      rd_state_q <= RIdle;
      rslot_q    <= '0;
      rptr_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_empty_q <= 1'b0;
      ch_valid_q <= '0;
      ch_ovf_q   <= '0;
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      wr_state_q <= wr_state_d;
      wslot_q    <= wslot_d;
      wptr_q     <= wptr_d;
      wovf_q     <= wovf_d;
      wr_err_q   <= wr_err_d;
      rd_state_q <= rd_state_d;
      rslot_q    <= rslot_d;
      rptr_q     <= rptr_d;
      rd_valid_q <= rd_valid_d;
      rd_empty_q <= rd_empty_d;
      ch_valid_q <= ch_valid_d;
      ch_ovf_q   <= ch_ovf_d;
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------- write FSM next state
  always_comb begin
    wr_state_d = wr_state_q;
    wslot_d    = wslot_q;
    wptr_d     = wptr_q;
    wovf_d     = wovf_q;
    wr_err_d   = 1'b0;
    wr_open    = 1'b0;
    wr_close   = 1'b0;

    // Append is evaluated first so a word arriving with commit is counted.
    if ((wr_state_q == WFill) && wr_en) begin
      if (wptr_q != SlotWords) begin
        wptr_d = wptr_q + 1'b1;
      end else begin
        wovf_d = 1'b1;
      end
    end

    unique case (wr_state_q)
      WIdle: begin
        if (wr_start) begin
          if (start_refused) begin
            wr_err_d = 1'b1;
          end else begin
            wr_open = 1'b1;
          end
        end
      end
      WFill: begin
        if (wr_abort) begin
          wr_state_d = WIdle;
        end else if (wr_commit) begin
          wr_state_d = WIdle;
          wr_close   = 1'b1;
        end else if (wr_start) begin
          if (start_refused) begin
            wr_err_d = 1'b1;
          end else begin
            wr_open = 1'b1;
          end
        end
      end
      default: wr_state_d = WIdle;
    endcase

    if (wr_open) begin
      wr_state_d = WFill;
      wslot_d    = wr_ch;
      wptr_d     = '0;
      wovf_d     = 1'b0;
    end
  end

  // ---------------------------------------------------------------- write FSM outputs
  always_comb begin
    ram_we    = (wr_state_q == WFill) && wr_en && (wptr_q != SlotWords);
    ram_waddr = {wslot_q, wptr_q[ADDR_WIDTH-1:0]};
  end

  // ---------------------------------------------------------------- read FSM next state
  always_comb begin
    rd_state_d = rd_state_q;
    rslot_d    = rslot_q;
    rptr_d     = rptr_q;
    rd_valid_d = rd_valid_q;
    rd_empty_d = 1'b0;
    rd_done    = 1'b0;

    unique case (rd_state_q)
      RIdle: begin
        if (rd_req) begin
          if (ch_valid_q[rd_ch]) begin
            rd_state_d = RFetch;
            rslot_d    = rd_ch;
            rptr_d     = '0;
          end else begin
            rd_empty_d = 1'b1;
          end
        end
      end
      RFetch: begin
        rd_state_d = RStream;
        rptr_d     = rptr_q + 1'b1;
        rd_valid_d = 1'b1;
      end
      RStream: begin
        if (rd_fire) begin
          if (rd_is_last) begin
            rd_state_d = RIdle;
            rd_valid_d = 1'b0;
            rd_done    = 1'b1;
          end else begin
            rptr_d = rptr_q + 1'b1;
          end
        end
      end
      default: rd_state_d = RIdle;
    endcase
  end

  // ---------------------------------------------------------------- read FSM outputs
  // The RAM read register is the output holding register: it only advances on a transfer,
  // which keeps q stable under back-pressure and gives one word per cycle with rd_ready high.
  always_comb begin
    ram_re    = (rd_state_q == RFetch) ||
                ((rd_state_q == RStream) && rd_fire && !rd_is_last);
    ram_raddr = {rslot_q, rptr_q[ADDR_WIDTH-1:0]};
  end

  // ---------------------------------------------------------------- slot tables
  always_comb begin
    ch_valid_d = ch_valid_q;
    ch_ovf_d   = ch_ovf_q;
    for (int i = 0; i < CH_NUM; i++) begin
      cnt_d[i] = cnt_q[i];
    end
    if (rd_done) begin
      ch_valid_d[rslot_q] = 1'b0;
      ch_ovf_d[rslot_q]   = 1'b0;
    end
    if (wr_open) begin
      ch_valid_d[wr_ch] = 1'b0;
    end
    if (wr_close) begin
      cnt_d[wslot_q]      = wptr_d;
      ch_valid_d[wslot_q] = (wptr_d != '0);
      ch_ovf_d[wslot_q]   = wovf_d;
    end
  end

  assign wr_err   = wr_err_q;
  assign rd_empty = rd_empty_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_is_last;
  assign q        = rd_valid_q ? ram_rdata : '0;
  assign ch_valid = ch_valid_q;
  assign ch_ovf   = ch_ovf_q;
  assign rd_cnt   = cnt_q[rd_ch];

endmodule
